// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word read at a time, queues returned words with
// their PCs, and hands them to decode in order. Redirects flush everything in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } state_t;

    state_t          state, state_next;
    logic [31:0]     fetch_pc, fetch_pc_next, pc_inc;
    entry_t          mem [DEPTH];
    entry_t          head, head_next, push_entry;
    logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_next;
    logic [CW-1:0]   count, count_next, remain;
    logic            push, pop, room;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Queue bookkeeping; a redirect cancels both push and pop.
    assign pc_inc      = fetch_pc + 32'd4;
    assign push        = (state == WAIT) & imem_rvalid & ~redirect_valid;
    assign pop         = (count != '0) & instr_ready & ~redirect_valid;
    assign count_next  = count + CW'(push) - CW'(pop);
    assign room        = count_next < CW'(DEPTH);
    assign remain      = count - CW'(pop);
    assign rd_ptr_next = rd_ptr + AW'(pop);
    assign push_entry  = '{pc: fetch_pc, word: imem_rdata};

    assign instr_valid = (count != '0) & ~redirect_valid;
    assign instr       = head.word;
    assign instr_pc    = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state, fetch PC and request strobe.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        imem_req      = 1'b0;
        imem_addr     = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            state_next    = ((state != FETCH) && !imem_rvalid) ? DISCARD : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (room) begin
                        imem_req   = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        fetch_pc_next = pc_inc;
                        imem_addr     = pc_inc;
                        if (room) begin
                            imem_req = 1'b1;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
        if (!rst_n) begin
            imem_req = 1'b0;
        end
    end

    // Head register tracks the oldest entry and holds its value once the queue drains.
    always_comb begin
        head_next = head;
        if (!redirect_valid) begin
            if (remain != '0) begin
                head_next = mem[rd_ptr_next];
            end else if (push) begin
                head_next = push_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head     <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            head     <= head_next;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count  <= count_next;
                rd_ptr <= rd_ptr_next;
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule
